// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: the 16 IEEE 1149.1 controller state codes,
// instruction opcodes and DR path selection used by the FSM and the core.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  // BYPASS is the all-ones opcode at whatever IR width is chosen.
  localparam int unsigned OPC_IDCODE = 1;
  localparam int unsigned OPC_USER   = 2;

  typedef enum logic [1:0] {
    PATH_BYPASS,
    PATH_IDCODE,
    PATH_USER
  } dr_path_t;

  // The IR column of the state diagram occupies codes SEL_IR..UPD_IR.
  function automatic logic is_ir_state(input tap_state_t s);
    return s >= SEL_IR;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state machine stepped by TMS on TCK rise,
// forced to Test-Logic-Reset asynchronously by TRST.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output logic [3:0] STATE,
  output logic [3:0] NEXT_STATE
);

  tap_state_t state_q;
  tap_state_t state_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) state_q <= TLR;
    else      state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    STATE      = state_q;
    NEXT_STATE = state_d;
  end

endmodule

// File: rtl/jtag_tap_core.sv
// TAP core: instruction register, BYPASS/IDCODE/USER data paths and TDO mux.
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register and make IDCODE the reset instruction.
module jtag_tap_core
  import jtag_tap_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          DR_W       = 32,
  parameter logic [31:0] IDCODE_VAL = 32'h1A5E_0001
) (
  input  logic            TCK,
  input  logic            TRST,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            TDO_EN,
  output logic [3:0]      STATE,
  output logic [IR_W-1:0] IR,
  input  logic [DR_W-1:0] USER_CAPTURE,
  output logic [DR_W-1:0] USER_UPDATE,
  output logic            USER_UPDATE_STB
);

  if (IR_W < 2 || IR_W > 8 || DR_W < 1 || DR_W > 64 || IDCODE_VAL[0] != 1'b1) begin : g_bad_cfg
    $error("jtag_tap_core: illegal IR_W, DR_W or IDCODE_VAL");
  end

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_W-1:0] RESET_INSTR = IR_W'(OPC_IDCODE);
`else
  localparam logic [IR_W-1:0] RESET_INSTR = '1;
`endif
  localparam logic [IR_W-1:0] USER_INSTR  = IR_W'(OPC_USER);
  localparam logic [IR_W-1:0] IR_CAPTURE  = IR_W'(2'b01);

  logic [3:0]      state_raw;
  logic [3:0]      next_raw;
  tap_state_t      state;
  tap_state_t      next_state;
  dr_path_t        path;

  logic [IR_W-1:0] ir_shift;
  logic [IR_W-1:0] ir_q;
  logic            bypass_q;
  logic [DR_W-1:0] user_shift;
  logic [DR_W-1:0] user_shifted;
  logic [DR_W-1:0] user_update_q;
  logic            stb_q;

  jtag_tap_fsm u_fsm (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .STATE      (state_raw),
    .NEXT_STATE (next_raw)
  );

  assign state      = tap_state_t'(state_raw);
  assign next_state = tap_state_t'(next_raw);

  // Anything not explicitly USER or (when built in) IDCODE falls to BYPASS.
  always_comb begin
    path = PATH_BYPASS;
    if (ir_q == USER_INSTR) path = PATH_USER;
`ifdef JTAG_TAP_IDCODE_EN
    else if (ir_q == IR_W'(OPC_IDCODE)) path = PATH_IDCODE;
`endif
  end

  // Loading the reset instruction on the edge that enters TLR keeps IR valid
  // for the whole time the controller sits in TLR.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift <= '0;
      ir_q     <= RESET_INSTR;
    end else begin
      case (state)
        CAP_IR:  ir_shift <= IR_CAPTURE;
        SH_IR:   ir_shift <= {TDI, ir_shift[IR_W-1:1]};
        default: ir_shift <= ir_shift;
      endcase
      if (next_state == TLR)   ir_q <= RESET_INSTR;
      else if (state == UPD_IR) ir_q <= ir_shift;
    end
  end

  if (DR_W > 1) begin : g_user_wide
    assign user_shifted = {TDI, user_shift[DR_W-1:1]};
  end else begin : g_user_narrow
    assign user_shifted = TDI;
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass_q      <= 1'b0;
      user_shift    <= '0;
      user_update_q <= '0;
      stb_q         <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      case (state)
        CAP_DR: begin
          bypass_q   <= 1'b0;
          user_shift <= USER_CAPTURE;
        end
        SH_DR: begin
          if (path == PATH_BYPASS) bypass_q   <= TDI;
          if (path == PATH_USER)   user_shift <= user_shifted;
        end
        UPD_DR: begin
          if (path == PATH_USER) begin
            user_update_q <= user_shift;
            stb_q         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_shift;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      idcode_shift <= '0;
    end else if (state == CAP_DR) begin
      idcode_shift <= IDCODE_VAL;
    end else if (state == SH_DR && path == PATH_IDCODE) begin
      idcode_shift <= {TDI, idcode_shift[31:1]};
    end
  end
`endif

  always_comb begin
    TDO = bypass_q;
    if (is_ir_state(state)) begin
      TDO = ir_shift[0];
    end else begin
      case (path)
        PATH_USER:   TDO = user_shift[0];
`ifdef JTAG_TAP_IDCODE_EN
        PATH_IDCODE: TDO = idcode_shift[0];
`endif
        default:     TDO = bypass_q;
      endcase
    end
  end

  assign TDO_EN          = (state == SH_DR) || (state == SH_IR);
  assign STATE           = state_raw;
  assign IR              = ir_q;
  assign USER_UPDATE     = user_update_q;
  assign USER_UPDATE_STB = stb_q;

endmodule
